blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
Controller that sequences a bank of NUM_CH blinker instances by driving each one's en and switch inputs and reading back its out.
Generates a programmable-rate tick and applies one of four patterns across a channel mask: off, all-toggle, chase, or finite burst.
Sits between a config source (switch/button decode or register block) and the blinker bank.
Accepts new configuration through a valid/ready handshake; every reconfiguration first drains all lamps to 0.

Parameters:
NUM_CH, 4, number of blinker channels driven
CNT_W, 24, width of tick prescaler and cfg_period
BURST_W, 4, width of cfg_burst (burst blink count)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration can be accepted this cycle
cfg_mode  in  2  0=OFF, 1=ALL, 2=CHASE, 3=BURST
cfg_period  in  CNT_W  clocks per tick; 0 treated as 1
cfg_burst  in  BURST_W  blinks per channel in BURST mode
cfg_mask  in  NUM_CH  channels participating
blink_state  in  NUM_CH  out of each blinker (feedback)
blink_en  out  NUM_CH  en to each blinker
blink_switch  out  NUM_CH  switch to each blinker
tick  out  1  one-cycle pulse at prescaler wrap (RUN only)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when BURST completes

Behaviour:
- Reset (async, reset_n=0): state=IDLE; prescaler=0; ptr=0; burst count=0; latched cfg=0; blink_en=0, blink_switch=0, tick=0, done=0, busy=0. cfg_ready=1.
- Blinker contract: blinker toggles at the next edge iff en=1 and switch=1. To force a lamp to 0, drive en=1 and switch=blink_state[i].
- Handshake: cfg_ready=1 in IDLE and RUN, 0 in DRAIN. Accept when cfg_valid&&cfg_ready.
  - On accept: latch mode/period/burst/mask; clear prescaler, burst count, ptr; next state DRAIN.
  - Accept in RUN aborts the current pattern; no done pulse.
- States:
  - IDLE: outputs 0.
  - DRAIN: blink_en=all ones, blink_switch=blink_state.
    - Exit when blink_state==0: to IDLE if mode=OFF, mask==0, or (BURST and burst==0); otherwise to RUN.
    - If entered from BURST completion, assert done for 1 cycle on exit to IDLE.
  - RUN:
    - Prescaler counts 0..P-1, where P=max(cfg_period,1); tick=1 in the cycle count==P-1, then count wraps to 0.
    - Unmasked channels are forced off every cycle: en=blink_state[i], switch=1.
- Masked-channel outputs in RUN:
  - ALL: on tick, en=switch=1 for masked channels; otherwise 0. Lamps toggle in unison.
  - CHASE: ptr names the lit channel.
    - On the first tick, ptr=lowest set mask bit.
    - On later ticks, ptr advances to the next set mask bit above ptr, wrapping to the lowest.
    - On each tick, en=1 and switch=blink_state[i]^(i==new ptr) for all masked channels, so exactly one masked lamp is lit after the edge.
    - Single-bit mask: that lamp stays lit.
  - BURST: as ALL, with a tick counter of width BURST_W+1.
    - After 2*cfg_burst ticks all lamps are back at 0; state goes to DRAIN with a completion flag, then to IDLE with done.
- Simultaneous events: cfg accept has priority over tick and over burst completion in the same cycle; the tick's toggle is still driven that cycle, and DRAIN cleans up afterwards.
- Latency: tick cycle drives en/switch combinationally from registered state; the lamp changes at the next clk edge.
- Outputs blink_en/blink_switch are combinational from registered state and blink_state. tick, done, and busy are combinational from registered state.

Decomposition:
- Shared package: mode encodings (MODE_OFF=0, MODE_ALL=1, MODE_CHASE=2, MODE_BURST=3) and state encodings (IDLE, DRAIN, RUN).
- Sub-module: tick_prescaler (CNT_W counter with clear, period-0-as-1, tick out), instantiated once.
- Next-set-bit search for CHASE is a function in this module.
- Registers use the team's dffr/dffre flops, with reset_n inverted at the flop.

Test Plan:
1. Reset mid-RUN (ALL, period=3): assert reset_n=0 -> blink_en=0, busy=0, cfg_ready=1 immediately, with no clock edge needed.
2. ALL, mask=4'b0101, period=3, lamps start 0 -> tick on cycles 3,6,9...; lamps 0,2 toggle together after each tick; lamps 1,3 stay 0.
3. CHASE, mask=4'b1011, period=1 -> lit lamp sequence 0,1,3,0,1,...; exactly one lamp at 1 after each tick.
4. BURST, burst=2, mask=4'b1111, period=2 -> 4 ticks, each lamp pulses twice, all end at 0, done pulses once, busy drops.
5. Reconfig during CHASE (lamp 3 lit) to OFF -> cfg_ready=0 in DRAIN; lamp 3 cleared next edge; IDLE; done stays 0.
6. period=0, mode ALL, mask=4'b0001 -> tick every cycle; lamp 0 toggles every cycle.

Source files
------------

// File: rtl/blink_sequencer_pkg.sv
// Shared encodings for the blinker-bank sequencer: pattern modes and controller states.
package blink_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/blink_sequencer_tick_prescaler.sv
// Free-running tick prescaler: counts 0..P-1 while run is high, P = max(period, 1).
module tick_prescaler
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last;

  assign last = (period == '0) ? '0 : period - CNT_W'(1);
  assign tick = run && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (run) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  dffr #(.W(CNT_W)) u_cnt (.clk(clk), .rst(~reset_n), .d(cnt_d), .q(cnt_q));

endmodule

// File: rtl/dffr.sv
// Plain flop (dffr) and load-enable flop (dffre), each with an async active-high reset to zero.
module dffr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

module dffre #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/blink_sequencer.sv
// Sequences a bank of blinkers through OFF/ALL/CHASE/BURST patterns; every new
// configuration first drains all lamps to 0 before the pattern starts.
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [NUM_CH-1:0]  cfg_mask,
  input  logic [NUM_CH-1:0]  blink_state,
  output logic [NUM_CH-1:0]  blink_en,
  output logic [NUM_CH-1:0]  blink_switch,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BCNT_W = BURST_W + 1;

  // First set bit strictly above 'from', wrapping; from = NUM_CH-1 yields the lowest set bit.
  function automatic logic [PTR_W-1:0] next_set(input logic [NUM_CH-1:0] mask,
                                                input logic [PTR_W-1:0]  from);
    logic [PTR_W-1:0] res;
    int unsigned      idx;
    res = from;
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      idx = (32'(from) + k) % NUM_CH;
      if (mask[PTR_W'(idx)]) res = PTR_W'(idx);
    end
    return res;
  endfunction

  logic [1:0]         state_q;
  state_e             state;
  state_e             state_d;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   period_q;
  logic [BURST_W-1:0] burst_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_new;
  logic               chase_go_q, chase_go_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               fin_q, fin_d;
  logic               accept;

  assign state     = state_e'(state_q);
  assign cfg_ready = (state != ST_DRAIN);
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = (state != ST_IDLE);
  // Completion flag survives into the first IDLE cycle so done is a registered-state pulse.
  assign done      = (state == ST_IDLE) && fin_q;
  assign ptr_new   = chase_go_q ? next_set(mask_q, ptr_q)
                                : next_set(mask_q, PTR_W'(NUM_CH - 1));

  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .run     (state == ST_RUN),
    .period  (period_q),
    .tick    (tick)
  );

  dffr  #(.W(2))       u_state  (.clk(clk), .rst(~reset_n), .d(state_d), .q(state_q));
  dffre #(.W(2))       u_mode   (.clk(clk), .rst(~reset_n), .en(accept), .d(cfg_mode),   .q(mode_q));
  dffre #(.W(CNT_W))   u_period (.clk(clk), .rst(~reset_n), .en(accept), .d(cfg_period), .q(period_q));
  dffre #(.W(BURST_W)) u_burst  (.clk(clk), .rst(~reset_n), .en(accept), .d(cfg_burst),  .q(burst_q));
  dffre #(.W(NUM_CH))  u_mask   (.clk(clk), .rst(~reset_n), .en(accept), .d(cfg_mask),   .q(mask_q));
  dffr  #(.W(PTR_W))   u_ptr    (.clk(clk), .rst(~reset_n), .d(ptr_d),      .q(ptr_q));
  dffr  #(.W(1))       u_go     (.clk(clk), .rst(~reset_n), .d(chase_go_d), .q(chase_go_q));
  dffr  #(.W(BCNT_W))  u_bcnt   (.clk(clk), .rst(~reset_n), .d(bcnt_d),     .q(bcnt_q));
  dffr  #(.W(1))       u_fin    (.clk(clk), .rst(~reset_n), .d(fin_d),      .q(fin_q));

  always_comb begin
    state_d    = state;
    ptr_d      = ptr_q;
    chase_go_d = chase_go_q;
    bcnt_d     = bcnt_q;
    fin_d      = fin_q;
    unique case (state)
      ST_IDLE: fin_d = 1'b0;
      ST_DRAIN: begin
        if (blink_state == '0) begin
          if (fin_q || mode_q == MODE_OFF || mask_q == '0 ||
              (mode_q == MODE_BURST && burst_q == '0))
            state_d = ST_IDLE;
          else
            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (mode_q == MODE_CHASE) begin
            ptr_d      = ptr_new;
            chase_go_d = 1'b1;
          end
          if (mode_q == MODE_BURST) begin
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (bcnt_d == {burst_q, 1'b0}) begin
              state_d = ST_DRAIN;
              fin_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Accept wins over tick/completion; the tick's toggle is still driven by the output logic.
    if (accept) begin
      state_d    = ST_DRAIN;
      ptr_d      = '0;
      chase_go_d = 1'b0;
      bcnt_d     = '0;
      fin_d      = 1'b0;
    end
  end

  always_comb begin
    blink_en     = '0;
    blink_switch = '0;
    unique case (state)
      ST_DRAIN: begin
        blink_en     = '1;
        blink_switch = blink_state;
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (!mask_q[PTR_W'(i)]) begin
            blink_en[PTR_W'(i)]     = blink_state[PTR_W'(i)];
            blink_switch[PTR_W'(i)] = 1'b1;
          end else if (tick) begin
            blink_en[PTR_W'(i)]     = 1'b1;
            blink_switch[PTR_W'(i)] = (mode_q == MODE_CHASE)
                                    ? (blink_state[PTR_W'(i)] ^ (PTR_W'(i) == ptr_new))
                                    : 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with a behavioural blinker bank and pattern model.
module tb_blink_sequencer;
  import blink_sequencer_pkg::*;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CNT_W   = 24;
  localparam int unsigned BURST_W = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [1:0]         cfg_mode = '0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic [NUM_CH-1:0]  cfg_mask = '0;
  logic [NUM_CH-1:0]  lamps;
  logic [NUM_CH-1:0]  blink_en, blink_switch;
  logic               tick, busy, done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  blink_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst), .cfg_mask(cfg_mask),
    .blink_state(lamps), .blink_en(blink_en), .blink_switch(blink_switch),
    .tick(tick), .busy(busy), .done(done)
  );

  // Blinker bank: toggles at the edge iff en && switch.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) lamps <= '0;
    else          lamps <= lamps ^ (blink_en & blink_switch);

  task automatic do_reset;
    @(negedge clk);
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic apply(input logic [1:0] mode, input int unsigned period,
                       input int unsigned burst, input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    cfg_mode   = mode;
    cfg_period = CNT_W'(period);
    cfg_burst  = BURST_W'(burst);
    cfg_mask   = mask;
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
    n_vec++; if (blink_en !== 4'b0000) begin n_err++; $display("FAIL rst_en got=%b exp=0000", blink_en); end
    n_vec++; if (blink_switch !== 4'b0000) begin n_err++; $display("FAIL rst_sw got=%b exp=0000", blink_switch); end
    n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick got=%b exp=0", tick); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
    apply(MODE_ALL, 3, 0, 4'b0101);
    repeat (5) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (blink_en !== 4'b0000) begin n_err++; $display("FAIL async_en got=%b exp=0000", blink_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_busy got=%b exp=0", busy); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL async_ready got=%b exp=1", cfg_ready); end
    n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL async_tick got=%b exp=0", tick); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_all(input logic [NUM_CH-1:0] mask, input int unsigned period,
                          input int unsigned ncyc);
    int unsigned       p;
    logic [NUM_CH-1:0] m_lamps;
    logic              exp_tick;
    p = (period == 0) ? 1 : period;
    m_lamps = '0;
    do_reset;
    apply(MODE_ALL, period, 0, mask);
    @(negedge clk);
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL all_drain_ready got=%b exp=0", cfg_ready); end
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      exp_tick = ((k % p) == p - 1);
      n_vec++; if (tick !== exp_tick) begin n_err++; $display("FAIL all_tick m=%b p=%0d k=%0d got=%b exp=%b", mask, period, k, tick, exp_tick); end
      n_vec++; if (lamps !== m_lamps) begin n_err++; $display("FAIL all_lamps m=%b p=%0d k=%0d got=%b exp=%b", mask, period, k, lamps, m_lamps); end
      if (exp_tick) m_lamps = m_lamps ^ mask;
    end
  endtask

  task automatic test_chase(input logic [NUM_CH-1:0] mask, input int unsigned period,
                            input int unsigned ncyc);
    int unsigned       bits[$];
    int unsigned       t;
    logic [NUM_CH-1:0] m_lamps;
    logic              exp_tick;
    bits.delete();
    for (int unsigned i = 0; i < NUM_CH; i++) if (mask[i]) bits.push_back(i);
    t = 0;
    m_lamps = '0;
    do_reset;
    apply(MODE_CHASE, period, 0, mask);
    @(negedge clk);
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(negedge clk);
      exp_tick = ((k % period) == period - 1);
      n_vec++; if (tick !== exp_tick) begin n_err++; $display("FAIL chase_tick m=%b k=%0d got=%b exp=%b", mask, k, tick, exp_tick); end
      n_vec++; if (lamps !== m_lamps) begin n_err++; $display("FAIL chase_lamps m=%b k=%0d got=%b exp=%b", mask, k, lamps, m_lamps); end
      if (t > 0) begin
        n_vec++; if ($countones(lamps) != 1) begin n_err++; $display("FAIL chase_onehot m=%b k=%0d got=%b exp=one lamp", mask, k, lamps); end
      end
      if (exp_tick) begin
        m_lamps = NUM_CH'(1 << bits[t % bits.size()]);
        t++;
      end
    end
  endtask

  task automatic test_burst(input logic [NUM_CH-1:0] mask, input int unsigned period,
                            input int unsigned burst);
    logic [NUM_CH-1:0] m_lamps;
    logic              exp_tick;
    m_lamps = '0;
    do_reset;
    apply(MODE_BURST, period, burst, mask);
    @(negedge clk);
    for (int unsigned k = 0; k < 2 * burst * period; k++) begin
      @(negedge clk);
      exp_tick = ((k % period) == period - 1);
      n_vec++; if (tick !== exp_tick) begin n_err++; $display("FAIL burst_tick b=%0d k=%0d got=%b exp=%b", burst, k, tick, exp_tick); end
      n_vec++; if (lamps !== m_lamps) begin n_err++; $display("FAIL burst_lamps b=%0d k=%0d got=%b exp=%b", burst, k, lamps, m_lamps); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL burst_early_done b=%0d k=%0d got=%b exp=0", burst, k, done); end
      if (exp_tick) m_lamps = m_lamps ^ mask;
    end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || lamps !== 4'b0000 || done !== 1'b0 || tick !== 1'b0) begin
      n_err++; $display("FAIL burst_final_drain got=busy%b lamps%b done%b tick%b exp=busy1 lamps0000 done0 tick0", busy, lamps, done, tick); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_idle_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL burst_done got=%b exp=1", done); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL burst_done_width got=%b exp=0", done); end
  endtask

  task automatic test_boundary;
    do_reset;
    apply(MODE_BURST, 2, 0, 4'b1111);
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL burst0_drain got=%b exp=1", busy); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL burst0_idle got=busy%b done%b exp=busy0 done0", busy, done); end
    apply(MODE_ALL, 1, 0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || tick !== 1'b0 || lamps !== 4'b0000) begin
      n_err++; $display("FAIL mask0_idle got=busy%b tick%b lamps%b exp=busy0 tick0 lamps0000", busy, tick, lamps); end
  endtask

  task automatic test_reconfig;
    int unsigned       seq[3];
    logic [NUM_CH-1:0] m_lamps;
    int unsigned       t;
    seq = '{0, 1, 3};
    m_lamps = '0;
    t = 0;
    do_reset;
    apply(MODE_CHASE, 4, 0, 4'b1011);
    @(negedge clk);
    for (int unsigned k = 0; k < 12; k++) begin
      @(negedge clk);
      n_vec++; if (lamps !== m_lamps) begin n_err++; $display("FAIL reconf_chase k=%0d got=%b exp=%b", k, lamps, m_lamps); end
      if (k % 4 == 3) begin m_lamps = NUM_CH'(1 << seq[t]); t++; end
    end
    apply(MODE_OFF, 1, 0, 4'b1111);
    @(negedge clk);
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reconf_ready got=%b exp=0", cfg_ready); end
    n_vec++; if (lamps !== 4'b1000) begin n_err++; $display("FAIL reconf_lit got=%b exp=1000", lamps); end
    n_vec++; if (blink_en !== 4'b1111 || blink_switch !== 4'b1000) begin
      n_err++; $display("FAIL reconf_drive got=en%b sw%b exp=en1111 sw1000", blink_en, blink_switch); end
    @(negedge clk);
    n_vec++; if (lamps !== 4'b0000 || done !== 1'b0) begin n_err++; $display("FAIL reconf_clear got=lamps%b done%b exp=lamps0000 done0", lamps, done); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reconf_idle got=busy%b done%b exp=busy0 done0", busy, done); end
  endtask

  task automatic test_back_to_back(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] mask2,
                                   input int unsigned period2, input int unsigned n);
    int unsigned       bits[$];
    logic [NUM_CH-1:0] m_lamps;
    logic              exp_tick;
    bits.delete();
    for (int unsigned i = 0; i < NUM_CH; i++) if (mask[i]) bits.push_back(i);
    do_reset;
    apply(MODE_CHASE, 1, 0, mask);
    @(negedge clk);
    repeat (n) @(negedge clk);
    // Accept lands on a tick cycle: that toggle still happens, then the drain takes two cycles.
    apply(MODE_ALL, period2, 0, mask2);
    m_lamps = NUM_CH'(1 << bits[n % bits.size()]);
    @(negedge clk);
    n_vec++; if (cfg_ready !== 1'b0 || lamps !== m_lamps) begin
      n_err++; $display("FAIL b2b_drain1 got=ready%b lamps%b exp=ready0 lamps%b", cfg_ready, lamps, m_lamps); end
    @(negedge clk);
    n_vec++; if (cfg_ready !== 1'b0 || lamps !== 4'b0000) begin
      n_err++; $display("FAIL b2b_drain2 got=ready%b lamps%b exp=ready0 lamps0000", cfg_ready, lamps); end
    m_lamps = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_tick = ((k % period2) == period2 - 1);
      n_vec++; if (tick !== exp_tick || lamps !== m_lamps) begin
        n_err++; $display("FAIL b2b_all k=%0d got=tick%b lamps%b exp=tick%b lamps%b", k, tick, lamps, exp_tick, m_lamps); end
      if (exp_tick) m_lamps = m_lamps ^ mask2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_all(4'b0101, 3, 12);
    test_all(4'b0001, 0, 8);
    repeat (3) test_all(NUM_CH'($urandom_range(1, 15)), $urandom_range(0, 4), 16);
    test_chase(4'b1011, 1, 9);
    test_chase(4'b0100, 2, 8);
    repeat (3) test_chase(NUM_CH'($urandom_range(1, 15)), $urandom_range(1, 3), 20);
    test_burst(4'b1111, 2, 2);
    repeat (3) test_burst(NUM_CH'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom_range(1, 5));
    test_boundary;
    test_reconfig;
    test_back_to_back(NUM_CH'($urandom_range(1, 15)), NUM_CH'($urandom_range(1, 15)),
                      $urandom_range(1, 3), $urandom_range(0, 6));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
